mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read memory between the instruction-fetch port and the load/store port of the RV32I core. It accepts at most one request per cycle and uses round-robin arbitration when both ports request. It generates byte enables and lane-replicated write data from the access size, and rejects misaligned accesses with an error response. It sits between the core and the unified program/data memory.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_be_gen.sv | 22 ++
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the instruction/load-store memory arbiter
package mem_arb_pkg;
  localparam int LANES = 4;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_e;
endpackage

// File: rtl/mem_be_gen.sv
// mem_be_gen: byte enables, lane-replicated write data and alignment check for one access
module mem_be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [LANES-1:0] be,
  output logic [31:0]      wdata_rep,
  output logic             misaligned
);
  always_comb begin
    be = size == SZ_BYTE ? 4'b0001 << addr :
         size == SZ_HALF ? 4'b0011 << addr :
         size == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    misaligned = size == SZ_ILL ||
                 (size == SZ_HALF && addr[0]) ||
                 (size == SZ_WORD && addr != 2'b00);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port sync-read memory between fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [LANES-1:0]  mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  owner_e last_q, owner_q;
  logic err_q, rd_q, mis, legal;
  logic [1:0] sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [LANES-1:0] be;
  logic [DATA_W-1:0] wrep;
  assign if_gnt = !rst && if_req && (!ls_req || last_q == OWN_LS);
  assign ls_gnt = !rst && ls_req && !if_gnt;
  assign sel_size = if_gnt ? SZ_WORD : ls_size;
  assign sel_addr = if_gnt ? if_addr : ls_addr;
  mem_be_gen u_be_gen (
    .size       (sel_size),
    .addr       (sel_addr[1:0]),
    .wdata      (ls_wdata),
    .be         (be),
    .wdata_rep  (wrep),
    .misaligned (mis)
  );
  always_comb begin
    legal = (if_gnt || ls_gnt) && !mis;
    mem_en = legal;
    mem_we = legal && ls_gnt && ls_we;
    mem_be = legal ? be : '0;
    mem_addr = legal ? sel_addr[ADDR_W-1:2] : '0;
    mem_wdata = mem_we ? wrep : '0;
    if_rvalid = !rst && owner_q == OWN_IF;
    if_err = if_rvalid && err_q;
    if_rdata = (if_rvalid && !err_q && rd_q) ? mem_rdata : '0;
    ls_rvalid = !rst && owner_q == OWN_LS;
    ls_err = ls_rvalid && err_q;
    ls_rdata = (ls_rvalid && !err_q && rd_q) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_LS;
      owner_q <= OWN_NONE;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      owner_q <= if_gnt ? OWN_IF : ls_gnt ? OWN_LS : OWN_NONE;
      err_q <= (if_gnt || ls_gnt) && mis;
      rd_q <= if_gnt || !ls_we;
      if (if_gnt || ls_gnt) last_q <= if_gnt ? OWN_IF : OWN_LS;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a rule-level model
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic [1:0] ls_size = 0;
  logic if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0] mem_be;
  logic [29:0] mem_addr;
  typedef struct {int cyc; bit is_ls; logic err; logic [31:0] rdata;} rsp_t;
  rsp_t q[$];
  logic [31:0] phys [16];
  logic [31:0] ref_mem [16];
  int cyc = 0, vectors = 0, miscompares = 0;
  bit m_last_ls = 1, m_gif = 0, m_gls = 0;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) phys[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= phys[mem_addr[3:0]];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  task automatic model_check();
    int nb;
    logic [31:0] a, wd;
    logic [3:0] be;
    bit e, ls;
    if (rst) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      q.delete();
      m_last_ls = 1;
      m_gif = 0;
      m_gls = 0;
      return;
    end
    m_gif = if_req && (!ls_req || m_last_ls);
    m_gls = ls_req && !m_gif;
    chk("if_gnt", if_gnt, m_gif);
    chk("ls_gnt", ls_gnt, m_gls);
    if (!m_gif && !m_gls) begin
      chk("idle_mem_en", mem_en, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_mem_be", mem_be, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_wdata, 0);
      return;
    end
    ls = m_gls;
    a = ls ? ls_addr : if_addr;
    nb = !ls ? 4 : ls_size == 0 ? 1 : ls_size == 1 ? 2 : ls_size == 2 ? 4 : 0;
    e = nb == 0 || (a % nb) != 0;
    m_last_ls = ls;
    chk("mem_en", mem_en, !e);
    if (!e) begin
      be = 4'(((1 << nb) - 1) << (a % 4));
      chk("mem_be", mem_be, be);
      chk("mem_addr", mem_addr, a / 4);
      chk("mem_we", mem_we, ls && ls_we);
      if (ls && ls_we) begin
        wd = nb == 1 ? ls_wdata[7:0] * 32'h0101_0101 :
             nb == 2 ? ls_wdata[15:0] * 32'h0001_0001 : ls_wdata;
        chk("mem_wdata", mem_wdata, wd);
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    q.push_back('{cyc, ls, e, (e || (ls && ls_we)) ? 32'h0 : ref_mem[a[5:2]]});
  endtask
  initial forever begin
    rsp_t h;
    bit have;
    @(negedge clk);
    #1;
    have = q.size() > 0 && q[0].cyc == cyc - 1;
    if (have) h = q.pop_front();
    chk("if_rvalid", if_rvalid, have && !h.is_ls);
    chk("ls_rvalid", ls_rvalid, have && h.is_ls);
    chk("if_err", if_err, have && !h.is_ls && h.err);
    chk("ls_err", ls_err, have && h.is_ls && h.err);
    chk("if_rdata", if_rdata, (have && !h.is_ls) ? h.rdata : 32'h0);
    chk("ls_rdata", ls_rdata, (have && h.is_ls) ? h.rdata : 32'h0);
  end
  task automatic step(input logic r, input logic ir, input logic [31:0] ia, input logic lr,
                      input logic we, input logic [1:0] sz, input logic [31:0] la,
                      input logic [31:0] wd);
    rst = r;
    if_req = ir;
    if_addr = ia;
    ls_req = lr;
    ls_we = we;
    ls_size = sz;
    ls_addr = la;
    ls_wdata = wd;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit ir, lr, we, r, ikeep, lkeep;
    logic [31:0] ia, la, wd;
    logic [1:0] sz;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      phys[i] = ref_mem[i];
    end
    ref_mem[2] = 32'h0051_0093;
    phys[2] = 32'h0051_0093;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2'b00, 32'h13, 32'h0000_00AB);
    step(0, 0, 0, 1, 1, 2'b01, 32'h12, 32'h0000_1234);
    step(0, 0, 0, 1, 0, 2'b10, 32'h02, 0);
    step(0, 0, 0, 1, 0, 2'b01, 32'h01, 0);
    step(0, 1, 32'h06, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 2'b10, 32'h10, 0);
    step(0, 0, 0, 1, 0, 2'b11, 32'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h08, 1, 0, 2'b10, 32'h10, 0);
    step(0, 0, 0, 1, 0, 2'b10, 32'h14, 0);
    step(1, 0, 0, 1, 0, 2'b10, 32'h14, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0C, 1, 0, 2'b10, 32'h14, 0);
    step(0, 1, 32'h0C, 1, 0, 2'b10, 32'h14, 0);
    ikeep = 0;
    lkeep = 0;
    ir = 0; ia = 0; lr = 0; we = 0; sz = 0; la = 0; wd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!ikeep) begin
        ir = $urandom_range(0, 1) == 1;
        ia = $urandom_range(0, 7) == 0 ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 15) * 4);
      end
      if (!lkeep) begin
        lr = $urandom_range(0, 1) == 1;
        we = $urandom_range(0, 1) == 1;
        sz = 2'($urandom_range(0, 3));
        la = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) la = la & ~(32'(sz == 2'b01 ? 1 : sz == 2'b10 ? 3 : 0));
        wd = $urandom;
      end
      r = $urandom_range(0, 99) == 0;
      step(r, ir, ia, lr, we, sz, la, wd);
      ikeep = ir && !m_gif && !r && $urandom_range(0, 3) != 0;
      lkeep = lr && !m_gls && !r && $urandom_range(0, 3) != 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
